voice_alloc_ctrl: RTL and testbench

Polyphonic voice allocator and scheduler for the bank of sawtooth oscillator voices. Accepts note-on/note-off events over a valid/ready handshake and assigns each event to one of NVOICES oscillator slots. Reuses a voice already holding the same note, otherwise takes a free voice, otherwise steals one round-robin. Drives each voice's 32-bit FREQUENCY word (8.24 phase increment) and gate, and sits between the event decoder and the oscillator bank.

---
 rtl/voice_alloc_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_voice_alloc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_alloc_ctrl.sv
// voice_alloc_ctrl: polyphonic voice allocator for the sawtooth oscillator bank.
// Each accepted note event scans all voices (one per cycle), then commits to
// a reused matching voice, the lowest free voice, or a round-robin stolen voice.
// Optional feature macro: SYNTH_GLIDE_EN (portamento toward a per-voice target).
module voice_alloc_ctrl #(
  parameter int NVOICES     = 4
`ifdef SYNTH_GLIDE_EN
  ,
  parameter int GLIDE_SHIFT = 4,
  parameter int GLIDE_DIV   = 256
`endif
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   LOCKED,
  input  logic                   EVT_VALID,
  output logic                   EVT_READY,
  input  logic                   EVT_ON,
  input  logic [6:0]             EVT_NOTE,
  input  logic [31:0]            EVT_FREQ,
  output logic [32*NVOICES-1:0]  FREQUENCY,
  output logic [NVOICES-1:0]     GATE,
  output logic [4:0]             ACTIVE_CNT
);

  localparam int IW = $clog2(NVOICES);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_t;

  state_t            state_q;
  logic              ready_q;
  logic [IW-1:0]     idx_q;
  logic              evt_on_q;
  logic [6:0]        evt_note_q;
  logic [31:0]       evt_freq_q;
  logic              match_found_q;
  logic [IW-1:0]     match_idx_q;
  logic              free_found_q;
  logic [IW-1:0]     free_idx_q;
  logic [IW-1:0]     steal_ptr_q;
  logic [NVOICES-1:0] gate_q;
  logic [6:0]        note_q [NVOICES];
  logic [31:0]       freq_q [NVOICES];
  logic [4:0]        active_q;

  logic [IW-1:0]     tgt_idx;
  logic              steal_hit;

  function automatic logic [4:0] popcount(input logic [NVOICES-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < NVOICES; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

`ifdef SYNTH_GLIDE_EN
  localparam int GW = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;

  logic [31:0]   tgt_q [NVOICES];
  logic [GW-1:0] glide_cnt_q;
  logic          glide_tick;

  // One step toward the target; a zero step snaps to it, so there is never overshoot.
  function automatic logic [31:0] glide_next(input logic [31:0] cur, input logic [31:0] tgt);
    logic [31:0] diff;
    logic [31:0] step;
    if (tgt >= cur) begin
      diff = tgt - cur;
      step = diff >> GLIDE_SHIFT;
      glide_next = (step == 32'd0) ? tgt : cur + step;
    end else begin
      diff = cur - tgt;
      step = diff >> GLIDE_SHIFT;
      glide_next = (step == 32'd0) ? tgt : cur - step;
    end
  endfunction

  assign glide_tick = (glide_cnt_q == GW'(GLIDE_DIV - 1));

  // Glide step timer: one tick every GLIDE_DIV cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      glide_cnt_q <= '0;
    end else if (glide_tick) begin
      glide_cnt_q <= '0;
    end else begin
      glide_cnt_q <= glide_cnt_q + 1'b1;
    end
  end
`endif

  // Commit target: matching voice first, then lowest free voice, else the steal pointer.
  always_comb begin
    tgt_idx   = steal_ptr_q;
    steal_hit = 1'b0;
    if (match_found_q) begin
      tgt_idx = match_idx_q;
    end else if (free_found_q) begin
      tgt_idx = free_idx_q;
    end else begin
      tgt_idx   = steal_ptr_q;
      steal_hit = evt_on_q;
    end
  end

  // Event FSM: intake handshake, per-voice scan, then voice state commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      idx_q         <= '0;
      evt_on_q      <= 1'b0;
      evt_note_q    <= 7'd0;
      evt_freq_q    <= 32'd0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      steal_ptr_q   <= '0;
      gate_q        <= '0;
      for (int k = 0; k < NVOICES; k++) begin
        note_q[k] <= 7'd0;
        freq_q[k] <= 32'd0;
`ifdef SYNTH_GLIDE_EN
        tgt_q[k]  <= 32'd0;
`endif
      end
    end else begin
`ifdef SYNTH_GLIDE_EN
      if (glide_tick) begin
        for (int k = 0; k < NVOICES; k++) begin
          freq_q[k] <= glide_next(freq_q[k], tgt_q[k]);
        end
      end
`endif
      case (state_q)
        IDLE: begin
          if (EVT_VALID && ready_q) begin
            evt_on_q      <= EVT_ON;
            evt_note_q    <= EVT_NOTE;
            evt_freq_q    <= EVT_FREQ;
            idx_q         <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            ready_q       <= 1'b0;
            state_q       <= SCAN;
          end else begin
            ready_q <= LOCKED;
          end
        end
        SCAN: begin
          if (gate_q[idx_q] && (note_q[idx_q] == evt_note_q) && !match_found_q) begin
            match_found_q <= 1'b1;
            match_idx_q   <= idx_q;
          end
          if (!gate_q[idx_q] && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
          if (idx_q == IW'(NVOICES - 1)) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        COMMIT: begin
          if (evt_on_q) begin
            gate_q[tgt_idx] <= 1'b1;
            note_q[tgt_idx] <= evt_note_q;
`ifdef SYNTH_GLIDE_EN
            tgt_q[tgt_idx]  <= evt_freq_q;
            if (!gate_q[tgt_idx]) begin
              freq_q[tgt_idx] <= evt_freq_q;
            end
`else
            freq_q[tgt_idx] <= evt_freq_q;
`endif
            if (steal_hit) begin
              steal_ptr_q <= (steal_ptr_q == IW'(NVOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
            end
          end else if (match_found_q) begin
            gate_q[match_idx_q] <= 1'b0;
`ifdef SYNTH_GLIDE_EN
            // Freeze any glide in progress at the current frequency.
            tgt_q[match_idx_q]  <= freq_q[match_idx_q];
            freq_q[match_idx_q] <= freq_q[match_idx_q];
`endif
          end
          ready_q <= LOCKED;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Gated-voice count, one cycle behind GATE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active_q <= 5'd0;
    end else begin
      active_q <= popcount(gate_q);
    end
  end

  for (genvar k = 0; k < NVOICES; k++) begin : g_freq_out
    assign FREQUENCY[32*k +: 32] = freq_q[k];
  end

  assign EVT_READY  = ready_q;
  assign GATE       = gate_q;
  assign ACTIVE_CNT = active_q;

endmodule

// File: tb/tb_voice_alloc_ctrl.sv
// Directed self-checking bench for voice_alloc_ctrl with NVOICES=4.
// With SYNTH_GLIDE_EN it runs GLIDE_DIV=1, GLIDE_SHIFT=1 and checks glide steps.
module tb_voice_alloc_ctrl;

  logic         CLK = 1'b0;
  logic         RST;
  logic         LOCKED;
  logic         EVT_VALID;
  logic         EVT_READY;
  logic         EVT_ON;
  logic [6:0]   EVT_NOTE;
  logic [31:0]  EVT_FREQ;
  logic [127:0] FREQUENCY;
  logic [3:0]   GATE;
  logic [4:0]   ACTIVE_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  voice_alloc_ctrl #(
    .NVOICES     (4)
`ifdef SYNTH_GLIDE_EN
    ,
    .GLIDE_SHIFT (1),
    .GLIDE_DIV   (1)
`endif
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOCKED     (LOCKED),
    .EVT_VALID  (EVT_VALID),
    .EVT_READY  (EVT_READY),
    .EVT_ON     (EVT_ON),
    .EVT_NOTE   (EVT_NOTE),
    .EVT_FREQ   (EVT_FREQ),
    .FREQUENCY  (FREQUENCY),
    .GATE       (GATE),
    .ACTIVE_CNT (ACTIVE_CNT)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_voices(input string tag, input logic [3:0] g,
                              input logic [31:0] f0, input logic [31:0] f1,
                              input logic [31:0] f2, input logic [31:0] f3);
    check_val({tag, "_gate"}, {28'd0, GATE}, {28'd0, g});
    check_val({tag, "_f0"}, FREQUENCY[31:0],   f0);
    check_val({tag, "_f1"}, FREQUENCY[63:32],  f1);
    check_val({tag, "_f2"}, FREQUENCY[95:64],  f2);
    check_val({tag, "_f3"}, FREQUENCY[127:96], f3);
  endtask

  task automatic check_cnt(input string tag, input logic [4:0] exp);
    check_val(tag, {27'd0, ACTIVE_CNT}, {27'd0, exp});
  endtask

  // Waits (bounded) for READY, performs the handshake on edge E0, then scrambles inputs.
  task automatic send(input logic on, input logic [6:0] note, input logic [31:0] freq);
    int waited;
    waited = 0;
    while (EVT_READY !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check_val("send_ready", {31'd0, EVT_READY}, 32'd1);
    EVT_VALID = 1'b1;
    EVT_ON    = on;
    EVT_NOTE  = note;
    EVT_FREQ  = freq;
    tick();
    EVT_VALID = 1'b0;
    EVT_ON    = ~on;
    EVT_NOTE  = 7'h55;
    EVT_FREQ  = 32'hDEADBEEF;
    check_val("ready_low_e0", {31'd0, EVT_READY}, 32'd0);
  endtask

  // Runs E1..E5: nothing may change through E4, the commit lands on E5.
  task automatic finish_evt(input logic [3:0] gate_before);
    repeat (4) tick();
    check_val("gate_e4", {28'd0, GATE}, {28'd0, gate_before});
    check_val("ready_e4", {31'd0, EVT_READY}, 32'd0);
    tick();
  endtask

  task automatic settle();
`ifdef SYNTH_GLIDE_EN
    repeat (40) tick();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST       = 1'b1;
    LOCKED    = 1'b1;
    EVT_VALID = 1'b0;
    EVT_ON    = 1'b0;
    EVT_NOTE  = 7'd0;
    EVT_FREQ  = 32'd0;
    repeat (3) tick();
    check_val("rst_ready", {31'd0, EVT_READY}, 32'd0);
    check_voices("rst", 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    check_cnt("rst_cnt", 5'd0);

    RST = 1'b0;
    tick();
    check_val("ready_after_rst", {31'd0, EVT_READY}, 32'd1);
    check_voices("post_rst", 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);

    // Fill voices 0..3 with free-voice allocation.
    send(1'b1, 7'd60, 32'h01000000);
    finish_evt(4'b0000);
    check_voices("on60", 4'b0001, 32'h01000000, 32'd0, 32'd0, 32'd0);
    check_cnt("cnt_lag", 5'd0);
    tick();
    check_cnt("cnt1", 5'd1);

    send(1'b1, 7'd64, 32'h01400000);
    finish_evt(4'b0001);
    check_voices("on64", 4'b0011, 32'h01000000, 32'h01400000, 32'd0, 32'd0);

    send(1'b1, 7'd67, 32'h01800000);
    finish_evt(4'b0011);
    check_voices("on67", 4'b0111, 32'h01000000, 32'h01400000, 32'h01800000, 32'd0);
    tick();
    check_cnt("cnt3", 5'd3);

    send(1'b1, 7'd69, 32'h01A00000);
    finish_evt(4'b0111);
    check_voices("on69", 4'b1111, 32'h01000000, 32'h01400000, 32'h01800000, 32'h01A00000);
    tick();
    check_cnt("cnt4", 5'd4);

    // Overflow: steal voice 0, then voice 1.
    send(1'b1, 7'd72, 32'h02000000);
    finish_evt(4'b1111);
`ifdef SYNTH_GLIDE_EN
    check_val("glide_s0", FREQUENCY[31:0], 32'h01000000);
    tick();
    check_val("glide_s1", FREQUENCY[31:0], 32'h01800000);
    tick();
    check_val("glide_s2", FREQUENCY[31:0], 32'h01C00000);
    settle();
`endif
    check_voices("steal0", 4'b1111, 32'h02000000, 32'h01400000, 32'h01800000, 32'h01A00000);

    send(1'b1, 7'd74, 32'h02400000);
    finish_evt(4'b1111);
    settle();
    check_voices("steal1", 4'b1111, 32'h02000000, 32'h02400000, 32'h01800000, 32'h01A00000);
    check_cnt("cnt_steal", 5'd4);

    // Note-off with a match: gate drops, frequency held.
    send(1'b0, 7'd74, 32'h12345678);
    finish_evt(4'b1111);
    check_voices("off74", 4'b1101, 32'h02000000, 32'h02400000, 32'h01800000, 32'h01A00000);
    tick();
    check_cnt("cnt_off", 5'd3);

    // Note-off without a match: dropped; READY returns right after the commit edge.
    send(1'b0, 7'd50, 32'h0);
    finish_evt(4'b1101);
    check_val("ready_back", {31'd0, EVT_READY}, 32'd1);
    check_voices("off50", 4'b1101, 32'h02000000, 32'h02400000, 32'h01800000, 32'h01A00000);

    // Retrigger of a gated voice reuses it and keeps the gate high.
    send(1'b1, 7'd67, 32'h01900000);
    finish_evt(4'b1101);
    check_val("retrig_gate", {28'd0, GATE}, 32'h0000000D);
    settle();
    check_val("retrig_f2", FREQUENCY[95:64], 32'h01900000);

    // Free voice 1 is taken with an immediate load; steal pointer is still at 2.
    send(1'b1, 7'd76, 32'h02800000);
    finish_evt(4'b1101);
    check_voices("free1", 4'b1111, 32'h02000000, 32'h02800000, 32'h01900000, 32'h01A00000);

    send(1'b1, 7'd77, 32'h03000000);
    finish_evt(4'b1111);
    settle();
    check_voices("steal2", 4'b1111, 32'h02000000, 32'h02800000, 32'h03000000, 32'h01A00000);

    // LOCKED low: no acceptance while VALID is held.
    LOCKED = 1'b0;
    tick();
    check_val("unlocked_ready", {31'd0, EVT_READY}, 32'd0);
    EVT_VALID = 1'b1;
    EVT_ON    = 1'b1;
    EVT_NOTE  = 7'd90;
    EVT_FREQ  = 32'h0F000000;
    repeat (8) tick();
    check_val("unlocked_ready2", {31'd0, EVT_READY}, 32'd0);
    check_voices("unlocked", 4'b1111, 32'h02000000, 32'h02800000, 32'h03000000, 32'h01A00000);
    EVT_VALID = 1'b0;
    LOCKED    = 1'b1;
    tick();
    check_val("relocked_ready", {31'd0, EVT_READY}, 32'd1);

    // Reset in the middle of SCAN: everything clears at once, event is lost.
    send(1'b0, 7'd72, 32'h0);
    tick();
    tick();
    RST = 1'b1;
    #1;
    check_voices("mid_rst", 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    check_cnt("mid_rst_cnt", 5'd0);
    check_val("mid_rst_ready", {31'd0, EVT_READY}, 32'd0);
    tick();
    RST = 1'b0;
    repeat (8) tick();
    check_val("lost_evt_gate", {28'd0, GATE}, 32'd0);
    check_val("post_mid_ready", {31'd0, EVT_READY}, 32'd1);

    // Allocation restarts cleanly from voice 0.
    send(1'b1, 7'd60, 32'h01000000);
    finish_evt(4'b0000);
    check_voices("restart", 4'b0001, 32'h01000000, 32'd0, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
